mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Sequences MEM-stage data-memory accesses for the 5-stage pipeline. Takes control/addr/data from the EX/MEM
//  register, drives a req/ack handshake to a variable-latency data memory, and holds the pipeline (stall_o)
//  until the access completes, times out or is rejected as misaligned. Sits between EX/MEM and MEM/WB.
// PARAMETERS
//  DATA_W     32   data/address width
//  TIMEOUT    255  max cycles in REQ without ack before abort (1..2^CNT_W-1)
//  CNT_W      8    timeout counter width
// PORTS
//  clk_i          in   1       clock, all state updates on rising edge
//  rst_i          in   1       synchronous reset, active high
//  MemRead_i      in   1       load in MEM stage (from EX/MEM)
//  MemWrite_i     in   1       store in MEM stage (from EX/MEM)
//  addr_i         in   DATA_W  ALU result = byte address
//  wdata_i        in   DATA_W  store data (Readdata2 from EX/MEM)
//  mem_req_o      out  1       request to data memory, registered
//  mem_we_o       out  1       1 = write, registered
//  mem_addr_o     out  DATA_W  registered address
//  mem_wdata_o    out  DATA_W  registered write data
//  mem_ack_i      in   1       memory completion, single-cycle pulse
//  mem_rdata_i    in   DATA_W  read data, valid with mem_ack_i
//  stall_o        out  1       freeze PC, IF/ID, ID/EX, EX/MEM; bubble into MEM/WB (combinational)
//  rdata_o        out  DATA_W  load result to MEM/WB, registered
//  done_o         out  1       access finished this cycle, registered, one-cycle pulse
//  err_o          out  1       done with error (timeout/misaligned), same cycle as done_o
// BEHAVIOUR
//  - States: IDLE, REQ, DONE. Reset (rst_i=1 at edge): state=IDLE, all registered outputs 0, counter 0.
//  - stall_o = !rst_i & ((IDLE & (MemRead_i|MemWrite_i)) | REQ). Low in DONE so pipeline advances that cycle.
//  - IDLE: no access -> stay. Access & addr_i[1:0]==0 -> REQ; latch addr/wdata, mem_req_o=1,
//    mem_we_o=MemWrite_i (write wins if both asserted). Access & misaligned -> DONE, err=1, no request issued.
//  - REQ: counter increments each cycle. mem_ack_i=1 -> DONE, rdata_o=mem_rdata_i (0 for writes), req dropped.
//    No ack and counter==TIMEOUT-1 -> DONE, err=1, rdata_o=0, req dropped. Ack takes priority over timeout.
//  - DONE: done_o=1 (and err_o if set) for exactly this cycle; inputs ignored (still show finished access);
//    next state IDLE unconditionally; counter cleared. rdata_o holds until next completion.
//  - Latency: access seen in IDLE cycle k; req high from k+1; ack in cycle m -> done_o at m+1. Min stall 2 cycles.
//  - mem_ack_i in IDLE/DONE ignored (stale ack after timeout must not corrupt rdata_o).
//  - mem_addr_o/mem_wdata_o/mem_we_o stable throughout REQ.
//  - Reset mid-REQ: next edge IDLE, mem_req_o=0, no done_o pulse; stall_o low while rst_i high.
// STRUCTURE
//  - Shared package (pipeline pkg): state encoding IDLE=2'd0, REQ=2'd1, DONE=2'd2; DATA_W default.
//  - One sub-module: mem_timeout_cnt (clear, enable, CNT_W, expire flag at TIMEOUT-1).
//  - FSM + output registers in top; stall_o single combinational assign.
// TESTING
//  1 load addr=0x10, ack after 3 REQ cycles, rdata=0xDEADBEEF -> stall 4 cycles, done_o, rdata_o=0xDEADBEEF, err_o=0.
//  2 store addr=0x20 wdata=0x1234, ack in first REQ cycle -> mem_we_o=1, addr/wdata stable, stall 2 cycles.
//  3 load addr=0x13 -> no mem_req_o, DONE next cycle, err_o=1, stall 1 cycle.
//  4 TIMEOUT=4, never ack -> req dropped after 4 REQ cycles, done_o+err_o, rdata_o=0; late ack ignored.
//  5 rst_i asserted in 2nd REQ cycle -> next cycle IDLE, all outputs 0, no done_o; new load then completes.
//  6 back-to-back load then store -> DONE->IDLE->REQ, no double issue of the first access.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: shared MEM-stage access state encoding and widths
package mem_access_ctrl_pkg;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/mem_access_ctrl_timeout_cnt.sv
// mem_timeout_cnt: cycle counter flagging expiry when it reaches TIMEOUT-1
module mem_timeout_cnt #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk_i) cnt_q <= rst_i ? '0 : cnt_d;
  assign expire_o = cnt_q == CNT_W'(TIMEOUT - 1);
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: req/ack sequencer for MEM-stage data accesses with pipeline stall
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              done_o,
  output logic              err_o
);
  state_e state_q, state_d;
  logic req_q, req_d, we_q, we_d, done_q, done_d, err_q, err_d, expire;
  logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic access;
  assign access = MemRead_i | MemWrite_i;
  mem_timeout_cnt #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (state_q != REQ),
    .en_i    (state_q == REQ),
    .expire_o(expire)
  );
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: if (access) begin
        done_d  = addr_i[1:0] != 2'b00;
        err_d   = done_d;
        state_d = done_d ? DONE : REQ;
        req_d   = !done_d;
        rdata_d = done_d ? '0 : rdata_q;
        if (!done_d) begin
          we_d    = MemWrite_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
        end
      end
      REQ: if (mem_ack_i || expire) begin
        // ack wins over an expiring counter in the same cycle
        state_d = DONE;
        req_d   = 1'b0;
        done_d  = 1'b1;
        err_d   = !mem_ack_i;
        rdata_d = (mem_ack_i && !we_q) ? mem_rdata_i : '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  assign stall_o     = !rst_i & (((state_q == IDLE) & access) | (state_q == REQ));
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign rdata_o     = rdata_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed vectors for the MEM-stage access sequencer
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  logic rst, rd, wr, ack;
  logic [31:0] addr, wdata, mrdata;
  logic req, we, stall, done, err;
  logic [31:0] maddr, mwdata, rdata;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  mem_access_ctrl #(.DATA_W(32), .TIMEOUT(4), .CNT_W(8)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .MemRead_i  (rd),
    .MemWrite_i (wr),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .mem_req_o  (req),
    .mem_we_o   (we),
    .mem_addr_o (maddr),
    .mem_wdata_o(mwdata),
    .mem_ack_i  (ack),
    .mem_rdata_i(mrdata),
    .stall_o    (stall),
    .rdata_o    (rdata),
    .done_o     (done),
    .err_o      (err)
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1; rd = 0; wr = 0; ack = 0; addr = 0; wdata = 0; mrdata = 0;
    cyc(); cyc();
    rd = 1; #1;
    chk("rst_stall", stall, 0);
    chk("rst_req", req, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    rst = 0; rd = 0; #1;
    chk("idle_stall", stall, 0);
    // 1: load, ack in third REQ cycle
    rd = 1; addr = 32'h10; #1;
    chk("t1_k_stall", stall, 1);
    chk("t1_k_req", req, 0);
    cyc();
    chk("t1_r1_req", req, 1);
    chk("t1_r1_we", we, 0);
    chk("t1_r1_addr", maddr, 32'h10);
    chk("t1_r1_stall", stall, 1);
    cyc();
    chk("t1_r2_stall", stall, 1);
    chk("t1_r2_done", done, 0);
    cyc();
    ack = 1; mrdata = 32'hDEADBEEF; #1;
    chk("t1_r3_stall", stall, 1);
    cyc();
    ack = 0; rd = 0; #1;
    chk("t1_done", done, 1);
    chk("t1_err", err, 0);
    chk("t1_rdata", rdata, 32'hDEADBEEF);
    chk("t1_done_stall", stall, 0);
    chk("t1_done_req", req, 0);
    cyc();
    chk("t1_pulse", done, 0);
    chk("t1_hold", rdata, 32'hDEADBEEF);
    // 2: store, ack in first REQ cycle; returned data must not reach rdata_o
    wr = 1; addr = 32'h20; wdata = 32'h1234; #1;
    chk("t2_k_stall", stall, 1);
    cyc();
    addr = 32'hFFFF_FFF0; wdata = 32'h9999; ack = 1; mrdata = 32'hFFFFFFFF; #1;
    chk("t2_req", req, 1);
    chk("t2_we", we, 1);
    chk("t2_addr", maddr, 32'h20);
    chk("t2_wdata", mwdata, 32'h1234);
    chk("t2_stall", stall, 1);
    cyc();
    ack = 0; wr = 0; #1;
    chk("t2_done", done, 1);
    chk("t2_err", err, 0);
    chk("t2_rdata", rdata, 0);
    chk("t2_stall_done", stall, 0);
    cyc();
    // 3: misaligned load
    rd = 1; addr = 32'h13; #1;
    chk("t3_stall", stall, 1);
    cyc();
    rd = 0; #1;
    chk("t3_req", req, 0);
    chk("t3_done", done, 1);
    chk("t3_err", err, 1);
    chk("t3_stall_done", stall, 0);
    cyc();
    // ack on the last cycle before the timeout would fire still wins
    rd = 1; addr = 32'h30; #1;
    cyc(); cyc(); cyc(); cyc();
    ack = 1; mrdata = 32'hCAFEF00D; #1;
    chk("b_r4_req", req, 1);
    cyc();
    ack = 0; rd = 0; #1;
    chk("b_done", done, 1);
    chk("b_err", err, 0);
    chk("b_rdata", rdata, 32'hCAFEF00D);
    cyc();
    // 4: timeout after four REQ cycles, then stale acks ignored
    rd = 1; addr = 32'h40; #1;
    cyc();
    chk("t4_r1_req", req, 1);
    cyc(); cyc(); cyc();
    chk("t4_r4_req", req, 1);
    chk("t4_r4_addr", maddr, 32'h40);
    chk("t4_r4_done", done, 0);
    cyc();
    ack = 1; mrdata = 32'h55; #1;
    chk("t4_req_drop", req, 0);
    chk("t4_done", done, 1);
    chk("t4_err", err, 1);
    chk("t4_rdata", rdata, 0);
    rd = 0; #1;
    cyc();
    chk("t4_late_ack_done", done, 0);
    chk("t4_late_ack_rdata", rdata, 0);
    chk("t4_late_ack_req", req, 0);
    cyc();
    ack = 0; #1;
    chk("t4_idle_ack_rdata", rdata, 0);
    // 5: reset in second REQ cycle
    rd = 1; addr = 32'h50; #1;
    cyc(); cyc();
    rst = 1; #1;
    chk("t5_rst_stall", stall, 0);
    cyc();
    rst = 0; rd = 0; #1;
    chk("t5_req", req, 0);
    chk("t5_we", we, 0);
    chk("t5_addr", maddr, 0);
    chk("t5_done", done, 0);
    chk("t5_err", err, 0);
    chk("t5_stall", stall, 0);
    cyc();
    chk("t5_nodone", done, 0);
    rd = 1; addr = 32'h60; #1;
    cyc();
    ack = 1; mrdata = 32'h0BADF00D; #1;
    chk("t5_new_req", req, 1);
    chk("t5_new_addr", maddr, 32'h60);
    cyc();
    ack = 0; rd = 0; #1;
    chk("t5_new_done", done, 1);
    chk("t5_new_rdata", rdata, 32'h0BADF00D);
    cyc();
    // 6: back-to-back load then store
    rd = 1; addr = 32'h70; #1;
    cyc();
    ack = 1; mrdata = 32'h11111111; #1;
    cyc();
    ack = 0; #1;
    chk("t6_ld_done", done, 1);
    chk("t6_ld_rdata", rdata, 32'h11111111);
    chk("t6_done_stall", stall, 0);
    rd = 0; wr = 1; addr = 32'h74; wdata = 32'hA5A5; #1;
    cyc();
    chk("t6_gap_req", req, 0);
    chk("t6_gap_done", done, 0);
    chk("t6_gap_stall", stall, 1);
    cyc();
    ack = 1; mrdata = 32'h77; #1;
    chk("t6_st_req", req, 1);
    chk("t6_st_we", we, 1);
    chk("t6_st_addr", maddr, 32'h74);
    chk("t6_st_wdata", mwdata, 32'hA5A5);
    cyc();
    ack = 0; wr = 0; #1;
    chk("t6_st_done", done, 1);
    chk("t6_st_rdata", rdata, 0);
    chk("t6_st_req_drop", req, 0);
    cyc();
    chk("t6_end_done", done, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
